uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It adds configurable data width, parity mode and stop-bit count, plus an internal transmit FIFO with a ready/overflow handshake. Frames are sent back-to-back with no idle gap. It sits between the host/bus write logic and the serial `tx` pin, in the same clock domain.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division truncating; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  write strobe; pushes tx_data into the FIFO when tx_ready=1.
- tx_data  input  DATA_BITS  word to transmit; sampled on the same edge as tx_start.
- tx_ready  output  1  FIFO not full (registered).
- tx_overflow  output  1  one-cycle pulse: tx_start was asserted while tx_ready=0.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while the FSM is not IDLE or fifo_count ≠ 0.

Behaviour:
- Reset (rst high at an edge):
  - Outputs after that edge: tx=1, tx_busy=0, tx_ready=1, tx_overflow=0, fifo_count=0.
  - FIFO is flushed; FSM goes to IDLE; baud counter and bit index clear.
  - Reset mid-frame aborts the frame; tx is high from the next cycle.
- FIFO push:
  - Occurs on an edge where tx_start=1 and tx_ready=1.
  - tx_ready is derived from the registered count. A push attempted while full is rejected even if a pop happens on the same edge; tx_overflow pulses on the following cycle and the data is dropped.
- Simultaneous push and pop (not full): fifo_count unchanged, both succeed. Word order is strict FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count≠0, pop the head into the shift register and enter START. The pop and entry happen on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0] (LSB first), each bit held CLKS_PER_BIT cycles. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx = ^data for even, ~^data for odd (total ones including the parity bit is even/odd respectively). Held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle, if fifo_count≠0 (evaluated that cycle, including a same-edge push into an empty FIFO), pop and go directly to START with no idle cycle; else go to IDLE.
- Latency: idle FSM, empty FIFO, tx_start sampled at edge N → word written at N, popped at N+1, tx falls after edge N+1 (two clocks).
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exact, with no jitter between bits.
- Baud counter: counts 0..CLKS_PER_BIT-1, restarts at every state or bit change, and never free-runs in IDLE.
- tx_busy falls on the same edge the FSM returns to IDLE with an empty FIFO.
- Only the low DATA_BITS of the shift register are transmitted; parity is computed over exactly DATA_BITS bits.

Test Plan:
1. Defaults except CLK_FREQ=1000000, BAUD_RATE=100000 (10 clk/bit); push 8'h3C → tx falls 2 clk after the strobe. Line sequence (10 cycles each): 0 | 0,0,1,1,1,1,0,0 | 1. tx_busy is high for 100+1 cycles and then low.
2. PARITY=2 with 8'h3C → parity bit 0; PARITY=1 with 8'h3C → parity bit 1; PARITY=1 with 8'h01 → parity bit 0. Frame is 110 cycles.
3. DATA_BITS=7, STOP_BITS=2, PARITY=0; push 7'h55 → data 1,0,1,0,1,0,1, then 20 high cycles. Total frame 100 cycles.
4. FIFO_DEPTH=4; push 5 words on consecutive cycles (0xA1..0xA5) → first word pops immediately, so all 5 are accepted and tx_ready stays high. Push 6 more while transmitting → tx_ready=0 once fifo_count=4, tx_overflow pulses once per rejected strobe. Output frames are contiguous in push order with zero idle cycles between stop and start.
5. Assert rst for 1 cycle in the middle of the DATA phase with 3 words queued → next cycle tx=1, fifo_count=0, tx_busy=0, tx_ready=1. No further frames appear.
6. FIFO full with a frame on its last stop cycle, tx_start asserted on that edge → the pop occurs, the push is rejected, tx_overflow=1 for 1 cycle, and fifo_count becomes 3.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a transmit FIFO. Frames leave back-to-back;
// data width, parity mode and stop-bit count are fixed at elaboration.
module uart_tx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_start,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx,
    output logic                          tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1'b1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Odd mode inverts so the total count of ones, parity bit included, is odd.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 2) begin
            parity_bit = ^d;
        end else begin
            parity_bit = ~^d;
        end
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_nxt_s;
    logic                   par_r, par_nxt_s;
    logic [3:0]             bit_r, bit_nxt_s;
    logic [BW-1:0]          baud_r, baud_nxt_s;
    logic                   tx_r, tx_nxt_s;
    logic                   busy_r, ready_r, ovf_r;
    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          count_r, count_nxt_s;
    logic                   push_s, pop_s, wr_en_s, rd_en_s, fifo_empty_s, baud_done_s;
    logic [DATA_BITS-1:0]   head_s;

    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign push_s       = tx_start & ready_r;
    // An empty FIFO hands a same-edge push straight to the shifter.
    assign head_s       = fifo_empty_s ? tx_data : mem_r[rd_ptr_r];
    assign baud_done_s  = (baud_r == BAUD_LAST);

    // Frame sequencer: next state, shifter, bit/baud counters and next line level.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        bit_nxt_s   = bit_r;
        baud_nxt_s  = {BW{1'b0}};
        pop_s       = 1'b0;
        tx_nxt_s    = 1'b1;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    par_nxt_s   = parity_bit(head_s);
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = S_DATA;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    shift_nxt_s = shift_r >> 1;
                    if (bit_r == DATA_LAST) begin
                        bit_nxt_s   = 4'd0;
                        state_nxt_s = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_nxt_s = bit_r + 4'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (baud_done_s) begin
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = S_STOP;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_done_s) begin
                    bit_nxt_s = 4'd0;
                    if (bit_r != STOP_LAST) begin
                        bit_nxt_s = bit_r + 4'd1;
                    end else if (!fifo_empty_s || push_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = head_s;
                        par_nxt_s   = parity_bit(head_s);
                        state_nxt_s = S_START;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        case (state_nxt_s)
            S_START:  tx_nxt_s = 1'b0;
            S_DATA:   tx_nxt_s = shift_nxt_s[0];
            S_PARITY: tx_nxt_s = par_nxt_s;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // FIFO bookkeeping; a bypassed word never touches the storage.
    always_comb begin
        wr_en_s     = push_s & ~(pop_s & fifo_empty_s);
        rd_en_s     = pop_s & ~fifo_empty_s;
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, only addressed through the reset pointers.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            shift_r  <= {DATA_BITS{1'b0}};
            par_r    <= 1'b0;
            bit_r    <= 4'd0;
            baud_r   <= {BW{1'b0}};
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
            ovf_r    <= 1'b0;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            shift_r  <= shift_nxt_s;
            par_r    <= par_nxt_s;
            bit_r    <= bit_nxt_s;
            baud_r   <= baud_nxt_s;
            tx_r     <= tx_nxt_s;
            busy_r   <= (state_nxt_s != S_IDLE) || (count_nxt_s != {CW{1'b0}});
            ready_r  <= (count_nxt_s != FULL_COUNT);
            ovf_r    <= tx_start & ~ready_r;
            count_r  <= count_nxt_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign tx          = tx_r;
    assign tx_busy     = busy_r;
    assign tx_ready    = ready_r;
    assign tx_overflow = ovf_r;
    assign fifo_count  = count_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations share one stimulus stream and are
// checked against a per-word schedule model (acceptance edge, start edge, frame bits).
module tb_uart_tx_param;

    localparam int CPB = 10;
    localparam int NI  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_w [NI];
    logic       busy_w [NI];
    logic       ready_w [NI];
    logic       ovf_w [NI];
    logic [2:0] cnt_w [NI];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         acc_t [NI][256];
    int         st_t  [NI][256];
    logic [7:0] dat   [NI][256];
    int         wn    [NI];
    logic       ovf_m [NI];

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ready(ready_w[0]), .tx_overflow(ovf_w[0]), .fifo_count(cnt_w[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]));
    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ready(ready_w[1]), .tx_overflow(ovf_w[1]), .fifo_count(cnt_w[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]));
    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ready(ready_w[2]), .tx_overflow(ovf_w[2]), .fifo_count(cnt_w[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]));
    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data[6:0]),
        .tx_ready(ready_w[3]), .tx_overflow(ovf_w[3]), .fifo_count(cnt_w[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]));

    function automatic int db_of(int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int par_of(int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
    endfunction
    function automatic int sb_of(int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int flen(int k);
        return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * CPB;
    endfunction

    // Line level of bit slot j of a frame carrying d.
    function automatic logic frame_bit(int k, logic [7:0] d, int j);
        int ones = 0;
        for (int i = 0; i < db_of(k); i++) ones += int'(d[i]);
        if (j == 0) return 1'b0;
        if (j <= db_of(k)) return d[j-1];
        if (par_of(k) != 0 && j == db_of(k) + 1)
            return (par_of(k) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        return 1'b1;
    endfunction

    function automatic int queued_before(int k, int t);
        int n = 0;
        for (int i = 0; i < wn[k]; i++) if (acc_t[k][i] < t && st_t[k][i] >= t) n++;
        return n;
    endfunction
    function automatic int exp_cnt(int k, int t);
        int n = 0;
        for (int i = 0; i < wn[k]; i++) if (acc_t[k][i] <= t && st_t[k][i] > t) n++;
        return n;
    endfunction
    function automatic logic exp_busy(int k, int t);
        for (int i = 0; i < wn[k]; i++) if (acc_t[k][i] <= t && st_t[k][i] + flen(k) > t) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic exp_tx(int k, int t);
        for (int i = 0; i < wn[k]; i++)
            if (st_t[k][i] <= t && t < st_t[k][i] + flen(k))
                return frame_bit(k, dat[k][i], (t - st_t[k][i]) / CPB);
        return 1'b1;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge.
    task automatic tick(input logic s, input logic [7:0] d, input logic r);
        int e, st;
        @(negedge clk);
        tx_start = s;
        tx_data  = d;
        rst      = r;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                wn[k]    = 0;
                ovf_m[k] = 1'b0;
            end else begin
                ovf_m[k] = s && (queued_before(k, cyc) >= 4);
                if (s && !ovf_m[k]) begin
                    e  = (wn[k] > 0) ? st_t[k][wn[k]-1] + flen(k) : -1000000;
                    st = (cyc > e) ? cyc + 1 : ((cyc == e) ? cyc : e);
                    acc_t[k][wn[k]] = cyc;
                    st_t[k][wn[k]]  = st;
                    dat[k][wn[k]]   = d;
                    wn[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hAA, 1'b1);
        for (int k = 0; k < NI; k++) begin
            n_cmp += 5;
            if (tx_w[k] !== 1'b1)    begin n_err++; $display("FAIL reset_tx[%0d]: got %b expected 1", k, tx_w[k]); end
            if (busy_w[k] !== 1'b0)  begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_w[k]); end
            if (ready_w[k] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b expected 1", k, ready_w[k]); end
            if (ovf_w[k] !== 1'b0)   begin n_err++; $display("FAIL reset_ovf[%0d]: got %b expected 0", k, ovf_w[k]); end
            if (cnt_w[k] !== 3'd0)   begin n_err++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, cnt_w[k]); end
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input logic par_even, input logic par_odd);
        int bc [NI];
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, d, 1'b0);
        n_cmp++;
        if (tx_w[0] !== 1'b1) begin n_err++; $display("FAIL frame_latency_hold: got %b expected 1", tx_w[0]); end
        for (int k = 0; k < NI; k++) bc[k] = int'(busy_w[k]);
        for (int n = 1; n <= 130; n++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (n == 1) begin
                n_cmp++;
                if (tx_w[0] !== 1'b0) begin n_err++; $display("FAIL frame_latency_fall: got %b expected 0", tx_w[0]); end
            end
            if (n == 95) begin
                n_cmp += 2;
                if (tx_w[1] !== par_even) begin n_err++; $display("FAIL parity_even d=%h: got %b expected %b", d, tx_w[1], par_even); end
                if (tx_w[2] !== par_odd)  begin n_err++; $display("FAIL parity_odd d=%h: got %b expected %b", d, tx_w[2], par_odd); end
            end
            for (int k = 0; k < NI; k++) begin
                bc[k] += int'(busy_w[k]);
                n_cmp += 2;
                if (tx_w[k] !== exp_tx(k, cyc)) begin n_err++; $display("FAIL frame_tx[%0d] cyc=%0d: got %b expected %b", k, cyc, tx_w[k], exp_tx(k, cyc)); end
                if (busy_w[k] !== exp_busy(k, cyc)) begin n_err++; $display("FAIL frame_busy[%0d] cyc=%0d: got %b expected %b", k, cyc, busy_w[k], exp_busy(k, cyc)); end
            end
        end
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (bc[k] != ((k == 1 || k == 2) ? 111 : 101))
                begin n_err++; $display("FAIL frame_busy_len[%0d]: got %0d expected %0d", k, bc[k], (k == 1 || k == 2) ? 111 : 101); end
        end
    endtask

    task automatic test_fifo_full();
        int ovf_n = 0;
        int busy_n = 0;
        tick(1'b0, 8'h00, 1'b1);
        for (int a = 0; a < 5; a++) begin
            tick(1'b1, 8'hA1 + 8'(a), 1'b0);
            busy_n += int'(busy_w[0]);
            n_cmp++;
            if (ovf_w[0] !== 1'b0) begin n_err++; $display("FAIL fill_ovf push %0d: got %b expected 0", a, ovf_w[0]); end
            if (a < 4) begin
                n_cmp++;
                if (ready_w[0] !== 1'b1) begin n_err++; $display("FAIL fill_ready push %0d: got %b expected 1", a, ready_w[0]); end
            end
        end
        n_cmp += 2;
        if (cnt_w[0] !== 3'd4)   begin n_err++; $display("FAIL fill_count: got %0d expected 4", cnt_w[0]); end
        if (ready_w[0] !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", ready_w[0]); end
        for (int j = 0; j < 6; j++) begin
            tick(1'b1, 8'hB0 + 8'(j), 1'b0);
            busy_n += int'(busy_w[0]);
            ovf_n  += int'(ovf_w[0]);
            for (int k = 0; k < NI; k++) begin
                n_cmp += 2;
                if (ovf_w[k] !== ovf_m[k]) begin n_err++; $display("FAIL full_ovf[%0d] cyc=%0d: got %b expected %b", k, cyc, ovf_w[k], ovf_m[k]); end
                if (cnt_w[k] !== 3'(exp_cnt(k, cyc))) begin n_err++; $display("FAIL full_cnt[%0d] cyc=%0d: got %0d expected %0d", k, cyc, cnt_w[k], exp_cnt(k, cyc)); end
            end
        end
        n_cmp++;
        if (ovf_n != 6) begin n_err++; $display("FAIL overflow_pulses: got %0d expected 6", ovf_n); end
        for (int n = 0; n < 600; n++) begin
            tick(1'b0, 8'h00, 1'b0);
            busy_n += int'(busy_w[0]);
            for (int k = 0; k < NI; k++) begin
                n_cmp += 3;
                if (tx_w[k] !== exp_tx(k, cyc)) begin n_err++; $display("FAIL drain_tx[%0d] cyc=%0d: got %b expected %b", k, cyc, tx_w[k], exp_tx(k, cyc)); end
                if (cnt_w[k] !== 3'(exp_cnt(k, cyc))) begin n_err++; $display("FAIL drain_cnt[%0d] cyc=%0d: got %0d expected %0d", k, cyc, cnt_w[k], exp_cnt(k, cyc)); end
                if (ready_w[k] !== (exp_cnt(k, cyc) < 4)) begin n_err++; $display("FAIL drain_ready[%0d] cyc=%0d: got %b", k, cyc, ready_w[k]); end
            end
        end
        n_cmp++;
        if (busy_n != 501) begin n_err++; $display("FAIL back_to_back_busy: got %0d expected 501", busy_n); end
    endtask

    task automatic test_midframe_reset();
        int t0;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h11, 1'b0);
        t0 = cyc;
        for (int a = 0; a < 3; a++) tick(1'b1, 8'h22 + 8'(a), 1'b0);
        n_cmp++;
        if (cnt_w[0] !== 3'd3) begin n_err++; $display("FAIL midreset_queued: got %0d expected 3", cnt_w[0]); end
        while (cyc < t0 + 45) tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < NI; k++) begin
            n_cmp += 4;
            if (tx_w[k] !== 1'b1)    begin n_err++; $display("FAIL midreset_tx[%0d]: got %b expected 1", k, tx_w[k]); end
            if (cnt_w[k] !== 3'd0)   begin n_err++; $display("FAIL midreset_cnt[%0d]: got %0d expected 0", k, cnt_w[k]); end
            if (busy_w[k] !== 1'b0)  begin n_err++; $display("FAIL midreset_busy[%0d]: got %b expected 0", k, busy_w[k]); end
            if (ready_w[k] !== 1'b1) begin n_err++; $display("FAIL midreset_ready[%0d]: got %b expected 1", k, ready_w[k]); end
        end
        for (int n = 0; n < 300; n++) begin
            tick(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < NI; k++) begin
                n_cmp += 2;
                if (tx_w[k] !== 1'b1)   begin n_err++; $display("FAIL post_reset_tx[%0d] cyc=%0d: got %b expected 1", k, cyc, tx_w[k]); end
                if (busy_w[k] !== 1'b0) begin n_err++; $display("FAIL post_reset_busy[%0d] cyc=%0d: got %b expected 0", k, cyc, busy_w[k]); end
            end
        end
    endtask

    // Push on the last stop edge: with the FIFO full (first) or empty (second).
    task automatic test_stop_edge_push(input bit full);
        int t0;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hC1, 1'b0);
        t0 = cyc;
        if (full) for (int a = 0; a < 4; a++) tick(1'b1, 8'hC2 + 8'(a), 1'b0);
        while (cyc < t0 + 100) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h5A, 1'b0);
        n_cmp += 3;
        if (cnt_w[0] !== (full ? 3'd3 : 3'd0)) begin n_err++; $display("FAIL stop_push_cnt full=%0d: got %0d expected %0d", full, cnt_w[0], full ? 3 : 0); end
        if (ovf_w[0] !== full)  begin n_err++; $display("FAIL stop_push_ovf full=%0d: got %b expected %b", full, ovf_w[0], full); end
        if (tx_w[0] !== 1'b0)   begin n_err++; $display("FAIL stop_push_start full=%0d: got %b expected 0", full, tx_w[0]); end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (ovf_w[0] !== 1'b0) begin n_err++; $display("FAIL stop_push_ovf_pulse: got %b expected 0", ovf_w[0]); end
        for (int n = 0; n < 450; n++) begin
            tick(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < NI; k++) begin
                n_cmp += 3;
                if (tx_w[k] !== exp_tx(k, cyc)) begin n_err++; $display("FAIL stop_push_tx[%0d] cyc=%0d: got %b expected %b", k, cyc, tx_w[k], exp_tx(k, cyc)); end
                if (cnt_w[k] !== 3'(exp_cnt(k, cyc))) begin n_err++; $display("FAIL stop_push_cnt[%0d] cyc=%0d: got %0d expected %0d", k, cyc, cnt_w[k], exp_cnt(k, cyc)); end
                if (busy_w[k] !== exp_busy(k, cyc)) begin n_err++; $display("FAIL stop_push_busy[%0d] cyc=%0d: got %b expected %b", k, cyc, busy_w[k], exp_busy(k, cyc)); end
            end
        end
    endtask

    task automatic test_random();
        logic s, r;
        logic [7:0] d;
        tick(1'b0, 8'h00, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            r = ($urandom_range(0, 499) == 0);
            tick(s, d, r);
            for (int k = 0; k < NI; k++) begin
                n_cmp += 5;
                if (tx_w[k] !== exp_tx(k, cyc)) begin n_err++; $display("FAIL rnd_tx[%0d] cyc=%0d: got %b expected %b", k, cyc, tx_w[k], exp_tx(k, cyc)); end
                if (busy_w[k] !== exp_busy(k, cyc)) begin n_err++; $display("FAIL rnd_busy[%0d] cyc=%0d: got %b expected %b", k, cyc, busy_w[k], exp_busy(k, cyc)); end
                if (cnt_w[k] !== 3'(exp_cnt(k, cyc))) begin n_err++; $display("FAIL rnd_cnt[%0d] cyc=%0d: got %0d expected %0d", k, cyc, cnt_w[k], exp_cnt(k, cyc)); end
                if (ready_w[k] !== (exp_cnt(k, cyc) < 4)) begin n_err++; $display("FAIL rnd_ready[%0d] cyc=%0d: got %b", k, cyc, ready_w[k]); end
                if (ovf_w[k] !== ovf_m[k]) begin n_err++; $display("FAIL rnd_ovf[%0d] cyc=%0d: got %b expected %b", k, cyc, ovf_w[k], ovf_m[k]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            wn[k]    = 0;
            ovf_m[k] = 1'b0;
        end
        test_reset();
        test_frame(8'h3C, 1'b0, 1'b1);
        test_frame(8'h01, 1'b1, 1'b0);
        test_frame(8'h55, 1'b0, 1'b1);
        test_fifo_full();
        test_midframe_reset();
        test_stop_edge_push(1'b1);
        test_stop_edge_push(1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
